bird_drop: RTL and testbench

BIRD_DROP -- requirements
Module: bird_drop

---
 rtl/bird_drop.sv | 139 +++++++++++++
 tb/tb_bird_drop.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_drop.sv
// Bird-drop sprite controller: launches a bird from the plane, integrates
// ballistic motion once per video frame and holds the landed bird on screen.
module bird_drop #(
  parameter int NUM_BIRDS     = 5,
  parameter int GRAVITY       = 8,
  parameter int MAX_Y_SPEED   = 512,
  parameter int Y_OFFSET      = 64,
  parameter int GROUND_Y      = 440,
  parameter int X_LIMIT       = 607,
  parameter int LANDED_FRAMES = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               dropKey,
  input  logic               reload,
  input  logic        [10:0] planeSpeed,
  input  logic signed [10:0] planeX,
  input  logic signed [10:0] planeY,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               birdVisible,
  output logic               landed,
  output logic        [2:0]  dropsLeft
);

  // state     | meaning
  // IDLE_ST   | bird hidden, position tracks the plane, waits for a drop edge
  // FLY_ST    | bird falling, latches collisions until the next frame pulse
  // SOF_ST    | one-cycle frame update: landing decision or motion step
  // LANDED_ST | bird frozen on screen for LANDED_FRAMES frames
  typedef enum logic [1:0] {IDLE_ST, FLY_ST, SOF_ST, LANDED_ST} state_t;

  localparam logic signed [31:0] GROUND_FP   = 32'(GROUND_Y * 64);
  localparam logic signed [31:0] X_LIMIT_FP  = 32'(X_LIMIT * 64);
  localparam logic signed [31:0] MAX_VY      = 32'(MAX_Y_SPEED);
  localparam logic signed [31:0] GRAVITY_FP  = 32'(GRAVITY);
  localparam logic signed [31:0] Y_OFFSET_PX = 32'(Y_OFFSET);
  localparam logic        [7:0]  LAST_FRAME  = 8'(LANDED_FRAMES - 1);
  localparam logic        [2:0]  FULL_LOAD   = 3'(NUM_BIRDS);

  state_t             state;
  logic signed [31:0] x_pos, y_pos, x_speed, y_speed;
  logic               hit_flag;
  logic               drop_key_d;
  logic        [7:0]  frame_cnt;
  logic        [2:0]  drops_left;
  logic               landed_r;

  logic               drop_edge;
  logic signed [31:0] plane_x_ext, plane_y_ext;
  logic signed [31:0] plane_x_fp, plane_y_fp;
  logic signed [31:0] x_next, y_next, y_speed_inc;

  assign drop_edge   = dropKey & ~drop_key_d;
  assign plane_x_ext = {{21{planeX[10]}}, planeX};
  assign plane_y_ext = {{21{planeY[10]}}, planeY};
  assign plane_x_fp  = plane_x_ext <<< 6;
  assign plane_y_fp  = (plane_y_ext + Y_OFFSET_PX) <<< 6;
  assign x_next      = x_pos + x_speed;
  assign y_next      = y_pos + y_speed;
  assign y_speed_inc = y_speed + GRAVITY_FP;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE_ST;
      x_pos      <= '0;
      y_pos      <= '0;
      x_speed    <= '0;
      y_speed    <= '0;
      hit_flag   <= 1'b0;
      drop_key_d <= 1'b0;
      frame_cnt  <= '0;
      drops_left <= FULL_LOAD;
      landed_r   <= 1'b0;
    end else begin
      drop_key_d <= dropKey;
      landed_r   <= 1'b0;
      case (state)
        IDLE_ST: begin
          x_pos <= plane_x_fp;
          y_pos <= plane_y_fp;
          // reload wins over a simultaneous drop edge
          if (reload) begin
            drops_left <= FULL_LOAD;
          end else if (drop_edge && drops_left != 3'd0) begin
            x_speed    <= {21'b0, planeSpeed};
            y_speed    <= '0;
            drops_left <= drops_left - 3'd1;
            state      <= FLY_ST;
          end
        end
        FLY_ST: begin
          if (collision) hit_flag <= 1'b1;
          if (startOfFrame) state <= SOF_ST;
        end
        SOF_ST: begin
          hit_flag <= 1'b0;
          if (hit_flag || collision) begin
            landed_r <= 1'b1;
            state    <= LANDED_ST;
          end else if (y_next >= GROUND_FP) begin
            y_pos    <= GROUND_FP;
            landed_r <= 1'b1;
            state    <= LANDED_ST;
          end else if (x_next > X_LIMIT_FP) begin
            landed_r <= 1'b1;
            state    <= LANDED_ST;
          end else begin
            x_pos   <= x_next;
            y_pos   <= y_next;
            y_speed <= (y_speed_inc > MAX_VY) ? MAX_VY : y_speed_inc;
            state   <= FLY_ST;
          end
        end
        LANDED_ST: begin
          if (startOfFrame) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= '0;
              state     <= IDLE_ST;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

  // Bits [16:6] are the arithmetic >>>6 result truncated to 11 bits.
  assign topLeftX    = x_pos[16:6];
  assign topLeftY    = y_pos[16:6];
  assign birdVisible = (state != IDLE_ST);
  assign landed      = landed_r;
  assign dropsLeft   = drops_left;

endmodule

// File: tb/tb_bird_drop.sv
// Directed bench for bird_drop: a reference flight model feeds a scoreboard
// of expected positions and landing pulses, checked two cycles after each frame pulse.
module tb_bird_drop;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               dropKey = 1'b0;
  logic               reload = 1'b0;
  logic        [10:0] planeSpeed = 11'd0;
  logic signed [10:0] planeX = 11'sd0;
  logic signed [10:0] planeY = 11'sd0;
  logic               collision = 1'b0;
  logic signed [10:0] topLeftX, topLeftY;
  logic               birdVisible, landed;
  logic        [2:0]  dropsLeft;

  bird_drop dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .dropKey(dropKey),
    .reload(reload), .planeSpeed(planeSpeed), .planeX(planeX), .planeY(planeY),
    .collision(collision), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .birdVisible(birdVisible), .landed(landed), .dropsLeft(dropsLeft)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic               land;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  int   mx, my, mvx, mvy;
  bit   m_hit;
  bit   m_landed;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_launch();
    mx    = int'(planeX) * 64;
    my    = (int'(planeY) + 64) * 64;
    mvx   = int'(planeSpeed);
    mvy   = 0;
    m_hit = 1'b0;
  endtask

  task automatic model_sof(input bit coll, output bit land);
    land = 1'b1;
    if (m_hit || coll) begin
    end else if (my + mvy >= 440 * 64) begin
      my = 440 * 64;
    end else if (mx + mvx > 607 * 64) begin
    end else begin
      mx  = mx + mvx;
      my  = my + mvy;
      mvy = (mvy + 8 > 512) ? 512 : mvy + 8;
      land = 1'b0;
    end
    m_hit = 1'b0;
  endtask

  task automatic frame(input bit coll);
    exp_t e, g;
    bit   l;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    collision = coll;
    model_sof(coll, l);
    e.land = l;
    e.x = 11'(mx >>> 6);
    e.y = 11'(my >>> 6);
    sb.push_back(e);
    m_landed = l;
    tick();
    collision = 1'b0;
    g = sb.pop_front();
    check("frame_x", topLeftX, g.x);
    check("frame_y", topLeftY, g.y);
    check("frame_landed", landed, g.land);
    if (g.land) begin
      tick();
      check("landed_pulse_end", landed, 1'b0);
    end
    repeat (3) tick();
  endtask

  task automatic drop(input logic [2:0] exp_left, input bit launches);
    dropKey = 1'b1;
    tick();
    dropKey = 1'b0;
    if (launches) model_launch();
    check("drop_visible", birdVisible, launches);
    check("drop_left", dropsLeft, exp_left);
    tick();
  endtask

  task automatic fly_until_land(input int max_frames, input string tag);
    int n;
    n = 0;
    m_landed = 1'b0;
    while (!m_landed && n < max_frames) begin
      frame(1'b0);
      n++;
    end
    check(tag, m_landed, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 1; i <= 15; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      check("hold_visible", birdVisible, (i == 15) ? 1'b0 : 1'b1);
      if (i < 15) check("hold_frozen_y", topLeftY, 11'(my >>> 6));
    end
  endtask

  initial begin
    planeX = 11'sd100;
    planeY = 11'sd20;
    planeSpeed = 11'd50;
    repeat (2) tick();
    check("rst_visible", birdVisible, 1'b0);
    check("rst_landed", landed, 1'b0);
    check("rst_left", dropsLeft, 3'd5);
    resetN = 1'b1;
    tick();
    check("idle_track_x", topLeftX, 11'sd100);
    check("idle_track_y", topLeftY, 11'sd84);

    // first flight: drifting right, lands on the ground
    drop(3'd4, 1'b1);
    frame(1'b0);
    check("sof1_x", topLeftX, 11'sd100);
    check("sof1_y", topLeftY, 11'sd84);
    frame(1'b0);
    check("sof2_x", topLeftX, 11'sd101);
    fly_until_land(200, "flight1_landed");
    check("flight1_ground", topLeftY, 11'sd440);
    wait_idle();

    // free fall with speed saturation
    planeSpeed = 11'd0;
    drop(3'd3, 1'b1);
    fly_until_land(200, "freefall_landed");
    check("freefall_ground", topLeftY, 11'sd440);
    check("freefall_vmax", mvy, 512);
    wait_idle();

    // collision mid-frame
    planeSpeed = 11'd30;
    drop(3'd2, 1'b1);
    frame(1'b0);
    tick();
    collision = 1'b1;
    m_hit = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    frame(1'b0);
    check("midcoll_landed", m_landed, 1'b1);
    wait_idle();

    // collision coincident with the frame update
    drop(3'd1, 1'b1);
    frame(1'b1);
    wait_idle();

    // last bird, then an ignored sixth drop
    drop(3'd0, 1'b1);
    frame(1'b1);
    wait_idle();
    drop(3'd0, 1'b0);

    // reload and drop edge together: reload only
    reload = 1'b1;
    dropKey = 1'b1;
    tick();
    check("reload_left", dropsLeft, 3'd5);
    check("reload_nolaunch", birdVisible, 1'b0);
    reload = 1'b0;
    dropKey = 1'b0;
    tick();

    // key held through a whole flight; reload while flying is ignored
    dropKey = 1'b1;
    tick();
    model_launch();
    check("held_launch", birdVisible, 1'b1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_in_flight", dropsLeft, 3'd4);
    frame(1'b1);
    wait_idle();
    repeat (3) tick();
    check("held_no_relaunch", birdVisible, 1'b0);
    check("held_left", dropsLeft, 3'd4);
    dropKey = 1'b0;
    tick();

    // reset mid-flight
    drop(3'd3, 1'b1);
    frame(1'b0);
    resetN = 1'b0;
    tick();
    check("midrst_visible", birdVisible, 1'b0);
    check("midrst_left", dropsLeft, 3'd5);
    check("midrst_landed", landed, 1'b0);
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_pulse", landed, 1'b0);
    end

    // right-edge landing on the first frame
    planeX = 11'sd600;
    planeSpeed = 11'd1000;
    drop(3'd4, 1'b1);
    frame(1'b0);
    check("xlimit_x", topLeftX, 11'sd600);
    check("xlimit_landed", m_landed, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
